// File: rtl/state_monitor_pkg.sv
// Shared definitions for the multi-channel state monitor: FSM encoding,
// default timer step and event-counter limits.
package state_monitor_pkg;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_TRANSIENT = 1'b1
  } state_t;

  localparam int STEP_DEFAULT = 10000;

  localparam int          EVT_CNT_W   = 8;
  localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = 8'hFF;

endpackage

// File: rtl/state_monitor_channel.sv
// One debounced channel: holds a TRANSIENT window after an input change,
// then commits the settled value to stable_state.
//
//   state        | meaning
//   ST_IDLE      | input matches stable_state; timer preloaded with window length
//   ST_TRANSIENT | window running; commit in_q to stable_state when timer hits 0
module state_monitor_channel
  import state_monitor_pkg::*;
#(
  parameter int DELAY_W = 4,
  parameter int STEP    = STEP_DEFAULT,
  parameter int CNT_W   = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_q,
  input  logic               in_prev,
  input  logic [DELAY_W-1:0] delay_sel,
  input  logic               retrig,
  output logic               transient,
  output logic               stable_state,
  output logic               change_pulse
);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] load_val;

  // Truncated modulo 2**CNT_W when the parameters are oversized.
  assign load_val = CNT_W'(int'(delay_sel) * STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      timer        <= '0;
      transient    <= 1'b0;
      stable_state <= 1'b0;
      change_pulse <= 1'b0;
    end else begin
      change_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          timer <= load_val;
          if (in_q != stable_state) begin
            state     <= ST_TRANSIENT;
            transient <= 1'b1;
          end
        end
        ST_TRANSIENT: begin
          if (retrig && (in_q != in_prev)) begin
            timer <= load_val;
          end else if (timer == '0) begin
            state        <= ST_IDLE;
            transient    <= 1'b0;
            stable_state <= in_q;
            change_pulse <= (in_q != stable_state);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          transient <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/state_monitor_mc.sv
// Multi-channel state monitor top: input sampling, per-channel debounce and,
// with STATE_MONITOR_EVT_CNT_EN defined, a saturating committed-event counter.
module state_monitor_mc
  import state_monitor_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DELAY_W  = 4,
  parameter int STEP     = STEP_DEFAULT,
  parameter int CNT_W    = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in_state,
  input  logic [DELAY_W-1:0]  delay_sel,
  input  logic                retrig,
  input  logic                clear_count,
  output logic [CHANNELS-1:0] transient,
  output logic [CHANNELS-1:0] stable_state,
  output logic [CHANNELS-1:0] change_pulse
`ifdef STATE_MONITOR_EVT_CNT_EN
  ,
  output logic [EVT_CNT_W-1:0] event_count
`endif
);

  logic [CHANNELS-1:0] in_q;
  logic [CHANNELS-1:0] in_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q    <= '0;
      in_prev <= '0;
    end else begin
      in_q    <= in_state;
      in_prev <= in_q;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_monitor_channel #(
      .DELAY_W (DELAY_W),
      .STEP    (STEP),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .in_q         (in_q[i]),
      .in_prev      (in_prev[i]),
      .delay_sel    (delay_sel),
      .retrig       (retrig),
      .transient    (transient[i]),
      .stable_state (stable_state[i]),
      .change_pulse (change_pulse[i])
    );
  end

`ifdef STATE_MONITOR_EVT_CNT_EN
  localparam int SUM_W = EVT_CNT_W + $clog2(CHANNELS + 1);

  logic [SUM_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop = pop + SUM_W'(change_pulse[i]);
    end
    sum = SUM_W'(event_count) + pop;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_count) begin
      event_count <= '0;
    end else if (sum > SUM_W'(EVT_CNT_MAX)) begin
      event_count <= EVT_CNT_MAX;
    end else begin
      event_count <= sum[EVT_CNT_W-1:0];
    end
  end
`else
  logic unused_clear_count;
  assign unused_clear_count = clear_count;
`endif

endmodule

// File: tb/tb_state_monitor_mc.sv
// Scoreboard bench for state_monitor_mc with STEP=4; event counter checks
// follow STATE_MONITOR_EVT_CNT_EN.
module tb_state_monitor_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_state;
  logic [3:0] delay_sel;
  logic       retrig;
  logic       clear_count;
  logic [7:0] transient;
  logic [7:0] stable_state;
  logic [7:0] change_pulse;
`ifdef STATE_MONITOR_EVT_CNT_EN
  logic [7:0] event_count;
`endif

  always #5 clk = ~clk;

  state_monitor_mc #(
    .CHANNELS (8),
    .DELAY_W  (4),
    .STEP     (4),
    .CNT_W    (18)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_state     (in_state),
    .delay_sel    (delay_sel),
    .retrig       (retrig),
    .clear_count  (clear_count),
    .transient    (transient),
    .stable_state (stable_state),
    .change_pulse (change_pulse)
`ifdef STATE_MONITOR_EVT_CNT_EN
    ,
    .event_count  (event_count)
`endif
  );

  typedef struct {
    logic [7:0] st;
    logic [7:0] pl;
  } pulse_exp_t;

  pulse_exp_t pulse_q[$];
  int         win_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         tlen    = 0;
  logic [7:0] exp_stable = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start a committed change: expect a window of wlen cycles and a pulse.
  task automatic push_change(input logic [7:0] nv, input int wlen);
    pulse_exp_t e;
    e.st = nv;
    e.pl = nv ^ exp_stable;
    exp_stable = nv;
    win_q.push_back(wlen);
    pulse_q.push_back(e);
    in_state = nv;
  endtask

  // Monitor: measures each transient window and checks every change pulse.
  always @(negedge clk) begin
    if (reset) begin
      tlen = 0;
    end else begin
      if (transient != 8'h00) begin
        tlen++;
      end else if (tlen != 0) begin
        if (win_q.size() == 0) begin
          check("unexpected_window", tlen, 0);
        end else begin
          check("window_len", tlen, win_q.pop_front());
        end
        tlen = 0;
      end
      if (change_pulse != 8'h00) begin
        if (pulse_q.size() == 0) begin
          check("unexpected_pulse", int'(change_pulse), 0);
        end else begin
          pulse_exp_t e;
          e = pulse_q.pop_front();
          check("pulse_mask", int'(change_pulse), int'(e.pl));
          check("pulse_stable", int'(stable_state), int'(e.st));
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    in_state    = 8'h00;
    delay_sel   = 4'd2;
    retrig      = 1'b0;
    clear_count = 1'b0;
    tick(3);
    check("rst_transient", int'(transient), 0);
    check("rst_stable", int'(stable_state), 0);
    check("rst_pulse", int'(change_pulse), 0);
`ifdef STATE_MONITOR_EVT_CNT_EN
    check("rst_event_count", int'(event_count), 0);
`endif
    reset = 1'b0;

    // Quiet input: monitor flags any window or pulse.
    tick(20);
    check("idle_stable", int'(stable_state), 0);
    check("idle_transient", int'(transient), 0);

    // Bit 0 rises, delay 2*4 -> 9-cycle window.
    push_change(8'h01, 9);
    tick(14);
    check("b0_stable", int'(stable_state), 8'h01);
`ifdef STATE_MONITOR_EVT_CNT_EN
    check("b0_event_count", int'(event_count), 1);
`endif

    push_change(8'h09, 9);
    tick(14);
    check("b3_stable", int'(stable_state), 8'h09);

    // Bounce on bit 3, one-shot: window stays 9, no commit change.
    win_q.push_back(9);
    in_state = 8'h01;
    tick(3);
    in_state = 8'h09;
    tick(14);
    check("bounce_oneshot_stable", int'(stable_state), 8'h09);

    // Same bounce with retrig: reload 3 cycles in -> 12-cycle window.
    retrig = 1'b1;
    win_q.push_back(12);
    in_state = 8'h01;
    tick(3);
    in_state = 8'h09;
    tick(16);
    check("bounce_retrig_stable", int'(stable_state), 8'h09);
`ifdef STATE_MONITOR_EVT_CNT_EN
    check("bounce_event_count", int'(event_count), 2);
`endif

    // All channels toggle with delay 0: 1-cycle windows, +8 per toggle.
    retrig    = 1'b0;
    delay_sel = 4'd0;
    for (int i = 0; i < 32; i++) begin
      push_change(exp_stable ^ 8'hFF, 1);
      tick(4);
`ifdef STATE_MONITOR_EVT_CNT_EN
      if (i == 30) check("evt_count_250", int'(event_count), 250);
`endif
    end
`ifdef STATE_MONITOR_EVT_CNT_EN
    check("evt_count_sat", int'(event_count), 255);
`endif

    // clear_count on the same edge the pulse would be counted.
    push_change(exp_stable ^ 8'hFF, 1);
    tick(3);
    clear_count = 1'b1;
    tick(1);
    clear_count = 1'b0;
`ifdef STATE_MONITOR_EVT_CNT_EN
    check("clear_wins", int'(event_count), 0);
`endif
    tick(2);
`ifdef STATE_MONITOR_EVT_CNT_EN
    check("clear_stays", int'(event_count), 0);
`endif
    check("pre_reset_stable", int'(stable_state), int'(exp_stable));

    // Reset mid-window aborts everything without a pulse.
    delay_sel = 4'd2;
    in_state  = exp_stable ^ 8'h01;
    tick(4);
    check("mid_window_transient", int'(transient), 8'h01);
    reset = 1'b1;
    in_state = 8'h00;
    tick(1);
    check("abort_transient", int'(transient), 0);
    check("abort_stable", int'(stable_state), 0);
    check("abort_pulse", int'(change_pulse), 0);
    reset = 1'b0;
    exp_stable = 8'h00;
    tick(12);
    check("post_reset_transient", int'(transient), 0);
    check("win_queue_empty", win_q.size(), 0);
    check("pulse_queue_empty", pulse_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/state_monitor_mc.md
# state_monitor_mc

Multi-channel, parametrised successor of the single-bank state monitor. It watches `CHANNELS` independent input lines. On a change it holds that channel in a TRANSIENT window of programmable length. When the window ends, it commits the new value as the channel's stable (debounced) state and reports the change. It sits between raw pad inputs and downstream logic or the LED outputs, and optionally keeps a saturating count of committed events.

## Interface
Parameters:
- `CHANNELS`, 8: number of monitored input lines.
- `DELAY_W`, 4: width of the delay selector.
- `STEP`, 10000: timer cycles per delay unit (1 s at 10 kHz).
- `CNT_W`, 18: per-channel timer width. Must satisfy `(2**DELAY_W-1)*STEP < 2**CNT_W`; otherwise the load value is truncated modulo `2**CNT_W`.

Ports:
- `clk`  in  1  — single clock; all logic on its rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `in_state`  in  CHANNELS  — raw, asynchronous-origin inputs. Sampled once per cycle.
- `delay_sel`  in  DELAY_W  — window length in units of `STEP`.
- `retrig`  in  1  — 1: a further input change during TRANSIENT reloads the timer. 0: one-shot.
- `clear_count`  in  1  — synchronous clear of `event_count`.
- `transient`  out  CHANNELS  — channel currently in TRANSIENT.
- `stable_state`  out  CHANNELS  — last committed value per channel.
- `change_pulse`  out  CHANNELS  — one-cycle pulse when a commit changes `stable_state`.
- `event_count`  out  8  — saturating count of committed changes. Present only with `STATE_MONITOR_EVT_CNT_EN`.

## Operation
- Reset: `in_q`, `in_prev`, `stable_state`, `transient`, `change_pulse`, `event_count` and all timers are 0. Every channel is in IDLE.
- Input sampling:
  - `in_q <= in_state` every cycle.
  - `in_prev <= in_q` every cycle.
- Per-channel FSM, IDLE to TRANSIENT:
  - While in IDLE, the timer loads `delay_sel*STEP`, computed at CNT_W width.
  - If `in_q[i] != stable_state[i]`, the channel goes to TRANSIENT.
- Per-channel FSM, in TRANSIENT:
  - The timer decrements by 1 each cycle.
  - If `retrig=1` and `in_q[i] != in_prev[i]`, the timer reloads `delay_sel*STEP` instead; reload wins over decrement.
  - When `timer==0` and there is no reload that cycle, the channel goes to IDLE and `stable_state[i] <= in_q[i]`.
  - `change_pulse[i]` is 1 for that one cycle only if the committed value differs from the old `stable_state[i]`.
  - If the input bounced back before the window expired, the commit makes no change and produces no pulse.
- `delay_sel` is used only at load or reload. Changing it mid-window does not affect the running timer.
- `delay_sel=0`: the window is a single cycle.
- Event counter:
  - Each cycle, add popcount(`change_pulse`) to `event_count`.
  - Saturate at 255; never wrap.
  - `clear_count` wins over a same-cycle increment, so the result is 0.
- Reset asserted mid-window aborts all windows. `stable_state` returns to 0 with no pulse.

## Timing
- An `in_state` change present before edge k is captured in `in_q` at edge k.
- `transient[i]` is high after edge k+1.
- With no reload, `transient[i]` stays high for exactly `delay_sel*STEP+1` cycles.
- `stable_state` and `change_pulse` update on the same edge that `transient` falls.
- `event_count` reflects a pulse one cycle after `change_pulse`.
- All outputs are registered; there are no combinational input-to-output paths.
- Channels are fully independent. Simultaneous changes on several channels run parallel windows.

## Configuration
- `STATE_MONITOR_EVT_CNT_EN` defined: the event counter, `clear_count` and `event_count` are present.
- Not defined:
  - The counter logic is removed.
  - The `event_count` port is absent.
  - `clear_count` is still present but ignored.
  - All other behaviour is identical.

## Structure
- Shared package `state_monitor_pkg` holds:
  - the FSM state enum (`ST_IDLE=0`, `ST_TRANSIENT=1`);
  - the default `STEP`;
  - the event-counter width and saturation constant.
- Sub-module `state_monitor_channel`: one instance per channel, generated `CHANNELS` times. Contents:
  - FSM, timer and stable register;
  - inputs `in_q`, `in_prev`, `delay_sel`, `retrig`;
  - outputs `transient`, `stable_state`, `change_pulse`.
- The top level owns input sampling and the event counter.

## Test plan
Directed scenarios use `STEP=4`.
- Reset, then `in_state` held at 0x00 for 20 cycles → all outputs 0; `transient` never asserts.
- Bit 0 goes 0→1 with `delay_sel=2` → `transient[0]` is high for 9 cycles, then `stable_state=0x01`, a single `change_pulse=0x01`, and `event_count=1`.
- Bit 3 pulses 1→0→1 within the window, with `retrig=0` → window length is unchanged; at commit, `stable_state[3]` is unchanged and there is no pulse.
- Same stimulus with `retrig=1` and the second edge 3 cycles into the window → window extends to 3+9 cycles from the first entry; commit value is checked.
- All 8 bits toggle simultaneously, with `delay_sel=0` → `transient=0xFF` for 1 cycle and `change_pulse=0xFF`. Repeating 32 times → `event_count` saturates at 255. `clear_count` together with a pulse → 0.
- `reset` asserted mid-window → next cycle `transient=0`, `stable_state=0`, no pulse.
